uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that lets several on-chip byte sources share one UART transmitter. It accepts bytes from up to eight requesters over a valid/ready handshake and launches them one at a time into the transmitter. It holds the transmitter's data input stable for the whole frame. It sits between the UART register file / debug sources and the transmitter inside the SoC UART.

## Interface
- NUM_REQ, 2: number of requesters, legal range 2..8.
- IDX_W, $clog2(NUM_REQ): width of the grant index, derived.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  requester i has a byte on req_data[8i+7:8i].
- req_data  input  8*NUM_REQ  packed request bytes.
- req_last  input  NUM_REQ  byte is the last of a message; used only with UART_TX_SCHED_LOCK_EN.
- req_ready  output  NUM_REQ  one-hot accept strobe, combinational.
- tx_busy  input  1  transmitter busy, low only while the transmitter is idle.
- tx_data_valid  output  1  one-cycle launch strobe to the transmitter.
- tx_data  output  8  byte to transmit, registered.
- grant_id  output  IDX_W  index of the requester that owns the current or last frame.
- sched_busy  output  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - LAUNCH: tx_data_valid=1 for exactly this cycle.
  - WAIT_BUSY: wait for tx_busy=1.
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE.
- Acceptance (IDLE only):
  - Requires |req_valid and tx_busy==0.
  - The winner is the first set req_valid bit searching upward from (grant_id+1) mod NUM_REQ, wrapping around.
  - req_ready[winner]=1 that cycle and all other bits are 0. Bytes are accepted only on req_valid&req_ready.
- On accept: tx_data<=winner's byte, grant_id<=winner, state<=LAUNCH.
- tx_data is held constant from LAUNCH until the next accept, because the transmitter samples it throughout its START phase.
- req_ready is 0 in every state except IDLE.
- If tx_busy=1 while in IDLE (foreign use or stuck line), the block accepts nothing and req_ready stays 0.
- Simultaneous requests: exactly one is granted per frame. Requesters that lose keep req_valid high and are served in round-robin order. No requester waits more than NUM_REQ-1 frames (without lock).
- WAIT_BUSY has no timeout. The transmitter guarantees busy rises the cycle after the launch.

## Timing
- Reset values: tx_data_valid=0, tx_data=8'h00, grant_id=NUM_REQ-1 (so requester 0 is checked first), sched_busy=0, state=IDLE, lock cleared. req_ready=0 while rst_n is low.
- Accept at cycle T:
  - LAUNCH (tx_data_valid=1) at T+1.
  - WAIT_BUSY at T+2; tx_busy expected to be 1 at T+2.
- WAIT_DONE exits the cycle after tx_busy is sampled 0. The earliest next accept is that cycle +1.
- Throughput: one byte per transmitter frame plus 3 clk of overhead.
- Reset asserted mid-frame: the FSM returns to IDLE immediately and the in-flight byte is dropped. The transmitter is reset by the same rst_n.

## Configuration
- UART_TX_SCHED_LOCK_EN defined:
  - Accepting a byte with req_last=0 locks the grant to that requester.
  - While locked, arbitration considers only that requester and waits for it even if others are valid.
  - Accepting a byte with req_last=1 clears the lock.
  - Reset clears the lock.
- UART_TX_SCHED_LOCK_EN undefined:
  - req_last is ignored (unconnected internally).
  - Arbitration is pure per-byte round-robin.

## Test plan
- Single byte: req_valid[0]=1, req_data=8'hA5 at T.
  - Expect req_ready[0]=1 at T and tx_data_valid=1 only at T+1.
  - Expect tx_data=8'hA5 held until tx_busy falls; grant_id=0.
- Fairness, NUM_REQ=3: all req_valid held high with bytes 8'h10/8'h20/8'h30.
  - Expect launch order 10,20,30,10,20,30.
  - Expect no byte launched while tx_busy=1.
- Busy blocking: tx_busy forced 1 in IDLE with req_valid=1.
  - Expect req_ready=0 and tx_data_valid=0 for 50 cycles.
  - Release tx_busy; expect the accept on the next cycle.
- Lock (macro defined): req0 sends 8'h11 (last=0) then 8'h22 (last=1); req1 holds 8'h33 valid throughout.
  - Expect order 11,22,33.
  - Without the macro, expect order 11,33,22.
- Reset mid-frame: assert rst_n=0 during WAIT_DONE.
  - Expect tx_data_valid=0, tx_data=8'h00, sched_busy=0 and req_ready=0 immediately.
  - After release, expect a fresh request to be granted starting from requester 0.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// uart_tx_scheduler_if: requester handshake and transmitter launch bundle.
// Rev 1.0
//------------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 2
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_busy;
  logic                 tx_data_valid;
  logic [7:0]           tx_data;
  logic [IDX_W-1:0]     grant_id;
  logic                 sched_busy;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data_valid, tx_data, grant_id, sched_busy
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data_valid, tx_data, grant_id, sched_busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// uart_tx_scheduler: round-robin launch of requester bytes into one UART TX.
// Option UART_TX_SCHED_LOCK_EN holds the grant until req_last. Rev 1.0
//------------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W+2:0]   w_sel;
  logic [7:0]         r_tx_data;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_found;
  logic               w_accept;
  logic               w_locked;
  logic               w_tx_valid;
  logic               w_sched_busy;

`ifdef UART_TX_SCHED_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
    end else if (w_accept) begin
      r_lock <= !bus.req_last[w_winner];
    end
  end

  assign w_locked = r_lock;
`else
  logic w_unused_last;
  assign w_unused_last = ^bus.req_last;
  assign w_locked      = 1'b0;
`endif

  // Search starts just above the last owner; offset NUM_REQ lands back on it.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_grant;
    w_idx    = r_grant;
    if (w_locked) begin
      w_found = bus.req_valid[r_grant];
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_idx = IDX_W'((int'(r_grant) + k) % NUM_REQ);
        if (!w_found && bus.req_valid[w_idx]) begin
          w_found  = 1'b1;
          w_winner = w_idx;
        end
      end
    end
  end

  // rst_n gates the strobe so nothing is offered while reset is held.
  assign w_accept = rst_n && (r_state == S_IDLE) && !bus.tx_busy && w_found;
  assign w_sel    = {w_winner, 3'b000};

  always_comb begin
    w_ready = '0;
    if (w_accept) begin
      w_ready[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tx_valid   = 1'b0;
    w_sched_busy = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_sched_busy = 1'b0;
        if (w_accept) w_state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_tx_valid  = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Byte stays put after the frame so the transmitter's START sampling is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data <= 8'h00;
      r_grant   <= IDX_W'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_tx_data <= bus.req_data[w_sel +: 8];
      r_grant   <= w_winner;
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.tx_data_valid = w_tx_valid;
  assign bus.tx_data       = r_tx_data;
  assign bus.grant_id      = r_grant;
  assign bus.sched_busy    = w_sched_busy;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_uart_tx_scheduler: directed checks with a simple busy-counter TX model.
// Rev 1.0
//------------------------------------------------------------------------------
module tb_uart_tx_scheduler;
  localparam int NUM_REQ = 3;
  localparam int FRAME   = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic       force_busy;
  logic [7:0] r_cnt;
  assign bus.tx_busy = force_busy | (r_cnt != 8'd0);

  // Transmitter stand-in: busy from the cycle after launch for FRAME cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= 8'd0;
    else if (bus.tx_data_valid) r_cnt <= 8'(FRAME);
    else if (r_cnt != 8'd0)    r_cnt <= r_cnt - 8'd1;
  end

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] log_q[$];
  logic       busy_launch;
  logic       bad;
  logic [2:0] rdy;
  int         n;
  int         n0;
  logic [7:0] exp_fair [6] = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30};
`ifdef UART_TX_SCHED_LOCK_EN
  logic [7:0] exp_lock [3] = '{8'h11, 8'h22, 8'h33};
`else
  logic [7:0] exp_lock [3] = '{8'h11, 8'h33, 8'h22};
`endif

  always @(negedge clk) begin
    if (rst_n && bus.tx_data_valid) begin
      log_q.push_back(bus.tx_data);
      if (bus.tx_busy) busy_launch = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    force_busy    = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_q.delete();
    busy_launch = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.sched_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(k < 200), 32'd1);
  endtask

  initial begin
    force_busy    = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_data  = '0;
    bus.req_last  = '0;
    busy_launch   = 1'b0;

    // Reset values, with requests pending while reset is held
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_valid", 32'(bus.tx_data_valid), 32'd0);
    check("rst_data", 32'(bus.tx_data), 32'h00);
    check("rst_grant", 32'(bus.grant_id), 32'd2);
    check("rst_busy", 32'(bus.sched_busy), 32'd0);

    // Single byte
    do_reset();
    @(posedge clk);
    #1 bus.req_valid = 3'b001; bus.req_data = {8'h00, 8'h00, 8'hA5};
    @(negedge clk);
    check("t1_ready", 32'(bus.req_ready), 32'b001);
    check("t1_valid_T", 32'(bus.tx_data_valid), 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 3'b000;
    @(negedge clk);
    check("t1_valid_T1", 32'(bus.tx_data_valid), 32'd1);
    check("t1_data", 32'(bus.tx_data), 32'hA5);
    check("t1_grant", 32'(bus.grant_id), 32'd0);
    @(negedge clk);
    check("t1_valid_T2", 32'(bus.tx_data_valid), 32'd0);
    check("t1_txbusy", 32'(bus.tx_busy), 32'd1);
    bad = 1'b0;
    n = 0;
    while (bus.sched_busy && n < 200) begin
      if (bus.tx_data != 8'hA5 || bus.tx_data_valid || bus.req_ready != 0) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check("t1_hold", 32'(bad), 32'd0);
    check("t1_done", 32'(n < 200), 32'd1);
    check("t1_after", 32'(bus.tx_data), 32'hA5);
    check("t1_launches", 32'(log_q.size()), 32'd1);

    // Fairness with all three requesters held valid
    do_reset();
    bus.req_data  = {8'h30, 8'h20, 8'h10};
    bus.req_valid = 3'b111;
    n = 0;
    while (log_q.size() < 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 3'b000;
    wait_idle("t2_idle");
    check("t2_count", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_order%0d", i), 32'(log_q.size() > i ? log_q[i] : 8'hFF), 32'(exp_fair[i]));
    end
    check("t2_busy_launch", 32'(busy_launch), 32'd0);

    // Busy blocking
    do_reset();
    force_busy    = 1'b1;
    bus.req_valid = 3'b001;
    bus.req_data  = {8'h00, 8'h00, 8'h5A};
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bus.req_ready != 0 || bus.tx_data_valid || bus.sched_busy) bad = 1'b1;
    end
    check("t3_blocked", 32'(bad), 32'd0);
    @(posedge clk);
    #1 force_busy = 1'b0;
    @(negedge clk);
    check("t3_ready", 32'(bus.req_ready), 32'b001);
    @(posedge clk);
    #1 bus.req_valid = 3'b000;
    @(negedge clk);
    check("t3_launch", 32'(bus.tx_data_valid), 32'd1);
    check("t3_data", 32'(bus.tx_data), 32'h5A);
    wait_idle("t3_idle");

    // Lock / message ordering
    do_reset();
    bus.req_data  = {8'h00, 8'h33, 8'h11};
    bus.req_last  = 3'b000;
    bus.req_valid = 3'b011;
    n0 = 0;
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      rdy = bus.req_ready;
      if (rdy == 0 && bus.req_valid == 0 && !bus.sched_busy) break;
      @(posedge clk);
      #1;
      if (rdy[0]) begin
        if (n0 == 0) begin
          bus.req_data[7:0] = 8'h22;
          bus.req_last[0]   = 1'b1;
        end else begin
          bus.req_valid[0] = 1'b0;
        end
        n0++;
      end
      if (rdy[1]) bus.req_valid[1] = 1'b0;
      n++;
    end
    check("t4_done", 32'(n < 600), 32'd1);
    check("t4_count", 32'(log_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_order%0d", i), 32'(log_q.size() > i ? log_q[i] : 8'hFF), 32'(exp_lock[i]));
    end

    // Reset during WAIT_DONE
    do_reset();
    bus.req_data  = {8'h00, 8'h77, 8'h44};
    bus.req_valid = 3'b010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ready != 3'b010 && n < 50);
    @(posedge clk);
    #1 bus.req_valid = 3'b000;
    n = 0;
    while (!bus.tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("t5_pre_busy", 32'(bus.sched_busy), 32'd1);
    check("t5_pre_data", 32'(bus.tx_data), 32'h77);
    bus.req_valid = 3'b011;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(bus.tx_data_valid), 32'd0);
    check("t5_rst_data", 32'(bus.tx_data), 32'h00);
    check("t5_rst_busy", 32'(bus.sched_busy), 32'd0);
    check("t5_rst_ready", 32'(bus.req_ready), 32'd0);
    check("t5_rst_grant", 32'(bus.grant_id), 32'd2);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready", 32'(bus.req_ready), 32'b001);
    @(posedge clk);
    #1 bus.req_valid = 3'b000;
    @(negedge clk);
    check("t5_launch", 32'(bus.tx_data_valid), 32'd1);
    check("t5_data", 32'(bus.tx_data), 32'h44);
    check("t5_grant", 32'(bus.grant_id), 32'd0);
    wait_idle("t5_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
